// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared PRBS generator/checker constants and checker state encoding
package lfsr_pkg;

  localparam int DEF_BITS = 3;
  localparam logic [DEF_BITS-1:0] DEF_TAPS = 3'h5;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // Feedback bit of the Fibonacci recurrence for a given register and tap mask.
  function automatic logic lfsr_feedback(input logic [31:0] r, input logic [31:0] taps);
    return ^(r & taps);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear (clear then increment)
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      // A same-cycle event survives the clear so it is not lost from the new window.
      q <= W'(inc);
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS checker; LFSR_CHK_BITCNT_EN adds bit_count output
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int              BITS         = DEF_BITS,
  parameter logic [BITS-1:0] TAPS         = DEF_TAPS,
  parameter int              LOCK_MATCHES = 4,
  parameter int              MISS_LIMIT   = 3,
  parameter int              ERR_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_errs,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
`ifdef LFSR_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_count
`endif
);

  localparam int SW = $clog2(BITS + 1);
  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int XW = $clog2(MISS_LIMIT + 1);

  chk_state_e      state_q, state_d;
  logic [BITS-1:0] r_q, r_d;
  logic [SW-1:0]   seed_q, seed_d;
  logic [MW-1:0]   match_q, match_d;
  logic [XW-1:0]   miss_q, miss_d;
  logic            locked_d;
  logic            err_pulse_d;
  logic            err_inc;
  logic            pred;
  logic            mismatch;
  logic [BITS-1:0] shift_rx;
  logic [BITS-1:0] shift_pred;

  assign pred       = lfsr_feedback(32'(r_q), 32'(TAPS));
  assign mismatch   = (bit_in != pred);
  assign shift_rx   = {r_q[BITS-2:0], bit_in};
  assign shift_pred = {r_q[BITS-2:0], pred};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SEED;
      r_q       <= '0;
      seed_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      seed_q    <= seed_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked    <= locked_d;
      err_pulse <= err_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    seed_d      = seed_q;
    match_d     = match_q;
    miss_d      = miss_q;
    locked_d    = locked;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    if (bit_valid) begin
      case (state_q)
        SEED: begin
          r_d = shift_rx;
          if (seed_q == SW'(BITS - 1)) begin
            state_d = VERIFY;
            seed_d  = '0;
            match_d = '0;
          end else begin
            seed_d = seed_q + 1'b1;
          end
        end
        VERIFY: begin
          r_d = shift_rx;
          // An all-zero register predicts zero forever, so it must never earn a match.
          if (mismatch || (r_q == '0)) begin
            match_d = '0;
          end else if (match_q == MW'(LOCK_MATCHES - 1)) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
            match_d  = '0;
            miss_d   = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        LOCKED: begin
          // Flywheel on our own prediction so a channel error is not fed back in.
          r_d = shift_pred;
          if (mismatch) begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            if (miss_q == XW'(MISS_LIMIT - 1)) begin
              state_d  = SEED;
              locked_d = 1'b0;
              r_d      = '0;
              seed_d   = '0;
              miss_d   = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: begin
          state_d  = SEED;
          r_d      = '0;
          seed_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_errs),
    .inc   (err_inc),
    .q     (err_count)
  );

`ifdef LFSR_CHK_BITCNT_EN
  sat_counter #(.W(32)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_errs),
    .inc   (bit_valid && (state_q == LOCKED)),
    .q     (bit_count)
  );
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed self-checking bench for lfsr_checker
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       clear_errs;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
`ifdef LFSR_CHK_BITCNT_EN
  logic [31:0] bit_count;
`endif

  lfsr_checker #(
    .BITS(3), .TAPS(3'h5), .LOCK_MATCHES(4), .MISS_LIMIT(3), .ERR_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .clear_errs (clear_errs),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
`ifdef LFSR_CHK_BITCNT_EN
    ,
    .bit_count  (bit_count)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] pat = 7'b0011101;
  int   gi;
  int   checks = 0;
  int   errors = 0;
  int   gap = 0;
  int   pulse_total;
  int   gap_pulse;
  logic locked_seen;
  logic s_locked;
  logic s_pulse;
  logic [7:0] s_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic gen_bit(input int idx);
    return pat[6 - (idx % 7)];
  endfunction

  // One valid bit (optionally inverted), then gap cycles when gap mode is on.
  task automatic send(input logic flip, input logic clr);
    bit_in     = gen_bit(gi) ^ flip;
    bit_valid  = 1'b1;
    clear_errs = clr;
    gi++;
    @(posedge clk);
    #1;
    s_locked = locked;
    s_pulse  = err_pulse;
    s_cnt    = err_count;
    if (err_pulse) pulse_total++;
    if (locked) locked_seen = 1'b1;
    bit_valid  = 1'b0;
    clear_errs = 1'b0;
    for (int k = 0; k < 2 * gap; k++) begin
      bit_in = ~bit_in;
      @(posedge clk);
      #1;
      if (err_pulse) gap_pulse++;
      if (locked !== s_locked || err_count !== s_cnt) gap_pulse++;
    end
  endtask

  task automatic send_raw(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    if (locked) locked_seen = 1'b1;
    bit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    clear_errs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n       = 1'b1;
    gi          = 0;
    pulse_total = 0;
    gap_pulse   = 0;
    locked_seen = 1'b0;
  endtask

  // Clean lock, single error, clear, triple error drop and relock.
  task automatic lock_and_errors(input string pfx);
    for (int i = 0; i < 6; i++) send(1'b0, 1'b0);
    check({pfx, "not_locked_6"}, s_locked, 1'b0);
    send(1'b0, 1'b0);
    check({pfx, "locked_7"}, s_locked, 1'b1);
    for (int i = 0; i < 93; i++) send(1'b0, 1'b0);
    check({pfx, "clean_pulses"}, pulse_total, 0);
    check({pfx, "clean_cnt"}, s_cnt, 0);
    check({pfx, "clean_locked"}, s_locked, 1'b1);
    send(1'b1, 1'b0);
    check({pfx, "single_pulse"}, s_pulse, 1'b1);
    check({pfx, "single_cnt"}, s_cnt, 1);
    check({pfx, "single_locked"}, s_locked, 1'b1);
    for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
    check({pfx, "no_mult_pulses"}, pulse_total, 1);
    check({pfx, "no_mult_cnt"}, s_cnt, 1);
    check({pfx, "gap_quiet"}, gap_pulse, 0);
    bit_valid  = 1'b0;
    clear_errs = 1'b1;
    @(posedge clk);
    #1;
    clear_errs = 1'b0;
    check({pfx, "clear_cnt"}, err_count, 0);
    check({pfx, "clear_keeps_lock"}, locked, 1'b1);
    pulse_total = 0;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 1'b0);
      check({pfx, "triple_pulse"}, s_pulse, 1'b1);
      check({pfx, "triple_lock"}, s_locked, (i < 2) ? 1'b1 : 1'b0);
    end
    check({pfx, "triple_cnt"}, s_cnt, 3);
    for (int i = 0; i < 6; i++) send(1'b0, 1'b0);
    check({pfx, "relock_not_6"}, s_locked, 1'b0);
    send(1'b0, 1'b0);
    check({pfx, "relock_7"}, s_locked, 1'b1);
    check({pfx, "relock_cnt"}, s_cnt, 3);
  endtask

  initial begin
    do_reset();
    check("reset_locked", locked, 1'b0);
    check("reset_pulse", err_pulse, 1'b0);
    check("reset_cnt", err_count, 0);

    lock_and_errors("cont_");

    for (int i = 0; i < 252; i++) begin
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
    end
    check("sat_reach", s_cnt, 255);
    check("sat_locked", s_locked, 1'b1);
    send(1'b1, 1'b0);
    check("sat_hold", s_cnt, 255);
    check("sat_pulse", s_pulse, 1'b1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b1);
    check("clear_with_err", s_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 1'b0);
      send(1'b1, 1'b0);
    end
    check("cnt_five", s_cnt, 5);
    check("five_locked", s_locked, 1'b1);

    rst_n     = 1'b0;
    bit_in    = ~gen_bit(gi);
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    bit_valid = 1'b0;
    check("midreset_locked", locked, 1'b0);
    check("midreset_cnt", err_count, 0);
    check("midreset_pulse", err_pulse, 1'b0);

    do_reset();
    for (int i = 0; i < 50; i++) send_raw(1'b0);
    check("stuck_never_locked", locked_seen, 1'b0);
    check("stuck_cnt", err_count, 0);

    do_reset();
    gap = 1;
    lock_and_errors("gap_");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
